// File: rtl/aes128_inv_keyex.sv
// AES-128 inverse key expansion: recovers all 11 round keys from the round-10 key,
// one round per clock, sharing an external combinational S-box.
module aes128_inv_keyex #(
   parameter int unsigned DLY = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [127:0]    i_lkey,
   input  logic            i_key_en,
   output logic [1407:0]   o_exkey,
   output logic [127:0]    o_key,
   output logic            o_key_ok,
   output logic            o_sbox_use,
   output logic [31:0]     o_sbox_din,
   input  logic [31:0]     i_sbox_dout
);

   // Register delays are not modelled in RTL; DLY is kept for interface compatibility.
   logic unused_dly;
   assign unused_dly = ^DLY;

   logic [127:0]  key_q, key_d;
   logic [127:0]  lkey_q, lkey_d;
   logic [1279:0] exkey_q, exkey_d;
   logic [3:0]    count_q, count_d;
   logic          key_ok_q, key_ok_d;

   logic [127:0]  s_k;
   logic [31:0]   p0, p1, p2, p3;
   logic [127:0]  p;
   logic [3:0]    step;
   logic [7:0]    rcon;
   logic          busy;

   always_comb begin
      s_k  = i_key_en ? i_lkey : key_q;
      // A fresh start always begins at the round-10 step, even when restarting mid-run.
      step = i_key_en ? 4'd0 : count_q;
      case (step)
         4'd0:    rcon = 8'h36;
         4'd1:    rcon = 8'h1b;
         4'd2:    rcon = 8'h80;
         4'd3:    rcon = 8'h40;
         4'd4:    rcon = 8'h20;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h08;
         4'd7:    rcon = 8'h04;
         4'd8:    rcon = 8'h02;
         4'd9:    rcon = 8'h01;
         default: rcon = 8'h00;
      endcase
      p3 = s_k[31:0]   ^ s_k[63:32];
      p2 = s_k[63:32]  ^ s_k[95:64];
      p1 = s_k[95:64]  ^ s_k[127:96];
      p0 = s_k[127:96] ^ i_sbox_dout ^ {rcon, 24'h000000};
      p  = {p0, p1, p2, p3};
      o_sbox_din = {p3[23:0], p3[31:24]};
      busy       = i_key_en | (count_q != 4'd0);
   end

   always_comb begin
      key_d    = busy ? p : key_q;
      exkey_d  = busy ? {p, exkey_q[1279:128]} : exkey_q;
      lkey_d   = i_key_en ? i_lkey : lkey_q;
      count_d  = count_q;
      key_ok_d = key_ok_q;
      if (i_key_en) begin
         count_d  = 4'd1;
         key_ok_d = 1'b0;
      end else if (count_q == 4'd9) begin
         count_d  = 4'd0;
         key_ok_d = 1'b1;
      end else if (count_q != 4'd0) begin
         count_d  = count_q + 4'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         key_q    <= '0;
         lkey_q   <= '0;
         exkey_q  <= '0;
         count_q  <= '0;
         key_ok_q <= 1'b0;
      end else begin
         key_q    <= key_d;
         lkey_q   <= lkey_d;
         exkey_q  <= exkey_d;
         count_q  <= count_d;
         key_ok_q <= key_ok_d;
      end
   end

   always_comb begin
      o_exkey    = {exkey_q, lkey_q};
      o_key      = exkey_q[1279:1152];
      o_key_ok   = key_ok_q & ~i_key_en;
      o_sbox_use = busy;
   end

endmodule
